// File: rtl/mcyc_stall_ctrl_pkg.sv
// rtl/mcyc_stall_ctrl_pkg.sv - shared codes, states and stall patterns for the multi-cycle EX sequencer
package mcyc_stall_ctrl_pkg;

    localparam logic [1:0] MCYC_NONE = 2'b00;
    localparam logic [1:0] MCYC_MADD = 2'b01;
    localparam logic [1:0] MCYC_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MADD2    = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DIV_DONE = 2'd3
    } mcyc_state_t;

    localparam int STALL_PC    = 0;
    localparam int STALL_IF_ID = 1;
    localparam int STALL_ID_EX = 2;
    localparam int STALL_EX_MEM = 3;

    // EX stall freezes everything up to and including the EX/MEM register.
    localparam logic [5:0] STALL_ID = (6'b1 << STALL_PC) | (6'b1 << STALL_IF_ID) |
                                      (6'b1 << STALL_ID_EX);
    localparam logic [5:0] STALL_EX = STALL_ID | (6'b1 << STALL_EX_MEM);

    localparam int DIV_TIMEOUT_DEF = 40;

endpackage

// File: rtl/mcyc_stall_ctrl.sv
// rtl/mcyc_stall_ctrl.sv - madd/msub and divider sequencer with per-stage stall generation
module mcyc_stall_ctrl
    import mcyc_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ex_mcyc_req_i,
    input  logic [63:0] ex_hilo_temp_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    input  logic        stallreq_id_i,
    input  logic        flush_i,
    output logic [5:0]  stall_o,
    output logic [1:0]  cnt_o,
    output logic [63:0] hilo_temp_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic [63:0] div_result_o,
    output logic        div_valid_o,
    output logic        div_err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mcyc_state_t      state;
    logic [CNT_W-1:0] div_cnt;
    logic             ex_stall;

    always_comb begin
        ex_stall = 1'b0;
        case (state)
            ST_IDLE:     ex_stall = (ex_mcyc_req_i == MCYC_MADD) || (ex_mcyc_req_i == MCYC_DIV);
            ST_DIV_BUSY: ex_stall = 1'b1;
            default:     ex_stall = 1'b0;
        endcase

        stall_o = 6'b0;
        if (!rst || flush_i) begin
            stall_o = 6'b0;
        end else if (ex_stall) begin
            stall_o = STALL_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            cnt_o        <= 2'b00;
            hilo_temp_o  <= 64'd0;
            div_result_o <= 64'd0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_valid_o  <= 1'b0;
            div_err_o    <= 1'b0;
        end else begin
            div_annul_o <= 1'b0;
            if (flush_i) begin
                // Only a running divider needs to be told to abort.
                div_annul_o <= (state == ST_DIV_BUSY);
                state       <= ST_IDLE;
                div_cnt     <= '0;
                cnt_o       <= 2'b00;
                div_start_o <= 1'b0;
                div_valid_o <= 1'b0;
                div_err_o   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ex_mcyc_req_i == MCYC_MADD) begin
                            hilo_temp_o <= ex_hilo_temp_i;
                            cnt_o       <= 2'b01;
                            state       <= ST_MADD2;
                        end else if (ex_mcyc_req_i == MCYC_DIV) begin
                            div_start_o <= 1'b1;
                            div_cnt     <= '0;
                            state       <= ST_DIV_BUSY;
                        end
                    end
                    ST_MADD2: begin
                        cnt_o <= 2'b00;
                        state <= ST_IDLE;
                    end
                    ST_DIV_BUSY: begin
                        if (div_cnt != CNT_LAST) begin
                            div_cnt <= div_cnt + CNT_ONE;
                        end
                        if (div_ready_i) begin
                            div_result_o <= div_result_i;
                            div_valid_o  <= 1'b1;
                            div_start_o  <= 1'b0;
                            state        <= ST_DIV_DONE;
                        end else if (div_cnt == CNT_LAST) begin
                            div_result_o <= 64'd0;
                            div_valid_o  <= 1'b1;
                            div_err_o    <= 1'b1;
                            div_start_o  <= 1'b0;
                            div_annul_o  <= 1'b1;
                            state        <= ST_DIV_DONE;
                        end
                    end
                    ST_DIV_DONE: begin
                        div_valid_o <= 1'b0;
                        div_err_o   <= 1'b0;
                        state       <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcyc_stall_ctrl.sv
// tb/tb_mcyc_stall_ctrl.sv - directed self-checking bench for mcyc_stall_ctrl
module tb_mcyc_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ex_mcyc_req_i;
    logic [63:0] ex_hilo_temp_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        stallreq_id_i;
    logic        flush_i;
    logic [5:0]  stall_o;
    logic [1:0]  cnt_o;
    logic [63:0] hilo_temp_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic [63:0] div_result_o;
    logic        div_valid_o;
    logic        div_err_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0]  S_EX = 6'b001111;
    localparam logic [5:0]  S_ID = 6'b000111;
    localparam logic [63:0] P1   = 64'h0000_0001_FFFF_FFFE;
    localparam logic [63:0] P2   = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] D1   = 64'h0000_0003_0000_0007;

    mcyc_stall_ctrl dut (
        .clk(clk), .rst(rst), .ex_mcyc_req_i(ex_mcyc_req_i), .ex_hilo_temp_i(ex_hilo_temp_i),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i), .stallreq_id_i(stallreq_id_i),
        .flush_i(flush_i), .stall_o(stall_o), .cnt_o(cnt_o), .hilo_temp_o(hilo_temp_o),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_result_o(div_result_o),
        .div_valid_o(div_valid_o), .div_err_o(div_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic madd_scenario(input logic [63:0] prod);
        ex_mcyc_req_i = 2'b01; ex_hilo_temp_i = prod;
        settle();
        check("madd_c0_stall", 64'(stall_o), 64'(S_EX));
        tick();
        settle();
        check("madd_c1_cnt", 64'(cnt_o), 64'd1);
        check("madd_c1_hilo", hilo_temp_o, prod);
        check("madd_c1_stall", 64'(stall_o), 64'd0);
        tick();
        ex_mcyc_req_i = 2'b00;
        settle();
        check("madd_c2_cnt", 64'(cnt_o), 64'd0);
        check("madd_c2_stall", 64'(stall_o), 64'd0);
    endtask

    initial begin
        rst = 1'b0; ex_mcyc_req_i = 2'b01; ex_hilo_temp_i = P2;
        div_ready_i = 1'b0; div_result_i = 64'd0; stallreq_id_i = 1'b0; flush_i = 1'b0;
        repeat (2) tick();
        settle();
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_cnt", 64'(cnt_o), 64'd0);
        check("rst_hilo", hilo_temp_o, 64'd0);
        check("rst_divres", div_result_o, 64'd0);
        check("rst_flags", {60'd0, div_start_o, div_annul_o, div_valid_o, div_err_o}, 64'd0);
        ex_mcyc_req_i = 2'b00;
        tick();
        rst = 1'b1;

        madd_scenario(P1);

        // divider completes in its fifth busy cycle
        ex_mcyc_req_i = 2'b10;
        settle();
        check("div_req_stall", 64'(stall_o), 64'(S_EX));
        tick();
        ex_mcyc_req_i = 2'b00;
        settle();
        check("div_start", 64'(div_start_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                div_ready_i = 1'b1; div_result_i = D1;
            end
            settle();
            check("div_busy_stall", 64'(stall_o), 64'(S_EX));
            tick();
        end
        div_ready_i = 1'b0; div_result_i = 64'd0;
        settle();
        check("div_done_valid", 64'(div_valid_o), 64'd1);
        check("div_done_result", div_result_o, D1);
        check("div_done_stall", 64'(stall_o), 64'd0);
        check("div_done_start", 64'(div_start_o), 64'd0);
        check("div_done_err", 64'(div_err_o), 64'd0);
        tick();
        settle();
        check("div_after_valid", 64'(div_valid_o), 64'd0);

        // divider never answers: abort in the 40th busy cycle
        ex_mcyc_req_i = 2'b10;
        tick();
        ex_mcyc_req_i = 2'b00;
        for (int i = 0; i < 40; i++) begin
            settle();
            check("to_busy_stall", 64'(stall_o), 64'(S_EX));
            check("to_busy_valid", 64'(div_valid_o), 64'd0);
            tick();
        end
        settle();
        check("to_err", 64'(div_err_o), 64'd1);
        check("to_valid", 64'(div_valid_o), 64'd1);
        check("to_annul", 64'(div_annul_o), 64'd1);
        check("to_result", div_result_o, 64'd0);
        check("to_start", 64'(div_start_o), 64'd0);
        tick();
        settle();
        check("to_annul_end", 64'(div_annul_o), 64'd0);
        check("to_err_end", 64'(div_err_o), 64'd0);

        // ID stall alone, then EX priority, then reserved request code
        stallreq_id_i = 1'b1;
        settle();
        check("id_stall", 64'(stall_o), 64'(S_ID));
        ex_mcyc_req_i = 2'b10;
        #1;
        check("id_ex_prio", 64'(stall_o), 64'(S_EX));
        ex_mcyc_req_i = 2'b11; stallreq_id_i = 1'b0;
        #1;
        check("rsvd_stall", 64'(stall_o), 64'd0);
        tick();
        settle();
        check("rsvd_cnt", 64'(cnt_o), 64'd0);
        check("rsvd_start", 64'(div_start_o), 64'd0);
        ex_mcyc_req_i = 2'b00;

        // flush on the third busy cycle together with div_ready_i
        ex_mcyc_req_i = 2'b10;
        tick();
        ex_mcyc_req_i = 2'b00;
        tick();
        tick();
        flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = D1;
        settle();
        check("fl_stall", 64'(stall_o), 64'd0);
        tick();
        flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0;
        settle();
        check("fl_annul", 64'(div_annul_o), 64'd1);
        check("fl_valid", 64'(div_valid_o), 64'd0);
        check("fl_start", 64'(div_start_o), 64'd0);
        check("fl_result_kept", div_result_o, 64'd0);
        check("fl_idle_stall", 64'(stall_o), 64'd0);
        tick();
        settle();
        check("fl_annul_end", 64'(div_annul_o), 64'd0);

        // reset mid-MADD2 acts before the next edge
        ex_mcyc_req_i = 2'b01; ex_hilo_temp_i = P2;
        tick();
        ex_mcyc_req_i = 2'b00;
        settle();
        check("rm_madd2_cnt", 64'(cnt_o), 64'd1);
        check("rm_madd2_hilo", hilo_temp_o, P2);
        ex_mcyc_req_i = 2'b01;
        #1;
        rst = 1'b0;
        #1;
        check("rm_cnt", 64'(cnt_o), 64'd0);
        check("rm_hilo", hilo_temp_o, 64'd0);
        check("rm_stall", 64'(stall_o), 64'd0);
        check("rm_divres", div_result_o, 64'd0);
        ex_mcyc_req_i = 2'b00;
        tick();
        rst = 1'b1;

        madd_scenario(P1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcyc_stall_ctrl.md
Name: mcyc_stall_ctrl

Overview:
- Pipeline sequencer for multi-cycle EX operations: madd/msub (2 cycles) and div (variable latency).
- Merges EX and ID stall requests into the per-stage stall vector.
- The vector drives pc, if_id, id_ex, ex_mem and mem_wb, so the EX-to-MEM register (wdata/wd/wreg/whilo/hi/lo) captures only completed results.
- Holds the madd/msub first-cycle product and the divider result between cycles.

Parameters:
- DIV_TIMEOUT, 40, max cycles spent in DIV_BUSY before forced abort.
- CNT_W, 6, width of the internal div cycle counter (must hold DIV_TIMEOUT).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (reset when rst=0)
- ex_mcyc_req_i  in  2  00 none, 01 madd/msub, 10 div, 11 reserved (treated as none)
- ex_hilo_temp_i  in  64  first-cycle product of madd/msub
- div_ready_i  in  1  divider result valid
- div_result_i  in  64  {remainder, quotient}
- stallreq_id_i  in  1  ID-stage stall request (load-use)
- flush_i  in  1  exception/flush; kills in-flight multi-cycle op
- stall_o  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (wb)
- cnt_o  out  2  00 first cycle, 01 second cycle of madd/msub
- hilo_temp_o  out  64  registered first-cycle product
- div_start_o  out  1  level: divider runs while high
- div_annul_o  out  1  one-cycle pulse: abort divider
- div_result_o  out  64  latched divider result
- div_valid_o  out  1  latched result valid this cycle
- div_err_o  out  1  high with div_valid_o when timeout abort occurred

Behaviour:
- Reset (rst=0, async): state IDLE; cnt_o=00; hilo_temp_o=0; div_result_o=0; div_start_o, div_annul_o, div_valid_o, div_err_o = 0; internal counter 0. stall_o is 0 while in reset.
- States: IDLE, MADD2, DIV_BUSY, DIV_DONE (encodings in shared defines).
- IDLE, req=01:
  - Combinationally assert ex_stall.
  - Next edge: hilo_temp_o<=ex_hilo_temp_i, cnt_o<=01, goto MADD2.
- MADD2:
  - ex_stall=0; the instruction completes using hilo_temp_o.
  - Next edge: cnt_o<=00, goto IDLE.
  - req is ignored (same instruction still in EX).
- IDLE, req=10:
  - Combinationally assert ex_stall.
  - Next edge: div_start_o<=1, counter<=0, goto DIV_BUSY.
- DIV_BUSY:
  - ex_stall=1; counter increments each cycle.
  - div_ready_i=1: div_result_o<=div_result_i, div_valid_o<=1, div_start_o<=0, goto DIV_DONE.
  - Else if counter==DIV_TIMEOUT-1: div_result_o<=0, div_valid_o<=1, div_err_o<=1, div_start_o<=0, div_annul_o pulses, goto DIV_DONE.
  - div_ready_i wins over timeout in the same cycle.
- DIV_DONE:
  - ex_stall=0; EX consumes div_result_o.
  - Next edge: div_valid_o<=0, div_err_o<=0, goto IDLE.
  - req is ignored.
- Minimum div latency is 3 cycles (request, ready-capture, consume).
- Stall encoding is combinational from state and inputs:
  - ex_stall: stall_o=6'b001111.
  - Else stallreq_id_i: stall_o=6'b000111.
  - Else stall_o=0.
  - EX request has priority over ID request.
- flush_i=1 (any state) wins over all other events:
  - stall_o=0 combinationally.
  - Next edge: goto IDLE, cnt_o<=00, div_start_o<=0, div_valid_o<=0, div_err_o<=0.
  - div_annul_o pulses for 1 cycle if the state was DIV_BUSY.
  - hilo_temp_o and div_result_o retain their values.
- flush in the same cycle as div_ready_i: the result is discarded and div_valid_o is not raised.
- Reset asserted mid-operation: immediate return to reset values; no annul pulse (the divider is reset by the same rst).
- Counter stops at DIV_TIMEOUT-1; no wrap.

Decomposition:
- Shared defines file:
  - mcyc request codes (MCYC_NONE/MADD/DIV)
  - state encodings
  - stall bit indices and the two stall patterns (STALL_EX=6'b001111, STALL_ID=6'b000111)
  - DIV_TIMEOUT default
- No sub-module required. Stall encoding stays a combinational always block inside.

Test Plan:
- req=01 with ex_hilo_temp_i=64'h0000_0001_FFFF_FFFE -> cycle0 stall_o=001111; cycle1 cnt_o=01, hilo_temp_o=64'h0000_0001_FFFF_FFFE, stall_o=0; cycle2 cnt_o=00.
- req=10, div_ready_i after 5 cycles with div_result_i=64'h0000_0003_0000_0007 -> stall_o=001111 throughout DIV_BUSY; then div_valid_o=1, div_result_o=64'h0000_0003_0000_0007, stall_o=0 for one cycle.
- req=10, div_ready_i never -> after DIV_TIMEOUT (40) cycles div_err_o=1, div_valid_o=1, div_annul_o one pulse, div_result_o=0.
- stallreq_id_i=1 with req=00 -> stall_o=000111. stallreq_id_i=1 with req=10 -> stall_o=001111.
- flush_i=1 at cycle 3 of DIV_BUSY with div_ready_i=1 -> stall_o=0 immediately, div_annul_o pulses, div_valid_o stays 0, state IDLE.
- rst driven low asynchronously mid-MADD2 -> all outputs reset before the next clk edge. After release, req=01 behaves as in the first scenario.
